// File: rtl/cms_ctrl_sequencer.sv
// cms_ctrl_sequencer
//
// Arbitrates control-register writes from two requesters onto the single
// ctrl_addr / ctrl_wdata / ctrl_write_enable bus of the continuous
// monitoring system. Requester 0 is the host (AXI GPIO) and requester 1 is
// the on-chip debug/trigger unit.
//
// Every accepted write is shaped as SETUP (1 cycle), STROBE (PULSE_CYCLES
// cycles) and HOLD (GAP_CYCLES cycles). Address and data stay stable across
// the whole sequence. This lets both posedge-triggered and level-triggered
// control modes in the monitor latch exactly once.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req0_* / req1_*        valid/ready write request channels (addr, wdata)
//   ctrl_addr, ctrl_wdata  registered write address/data to the monitor
//   ctrl_write_enable      write strobe to the monitor
//   busy                   high whenever the sequencer is not idle
//   issued_count           number of strobes issued, wraps modulo 2^32
//   drop_count             (only with CMS_CTRL_SEQ_ADDR_CHECK_EN) saturating
//                          count of writes dropped for an out-of-range address
//
// Optional feature macro: CMS_CTRL_SEQ_ADDR_CHECK_EN
//   When defined, handshakes whose address is above 9 (ADDR_CLK_COUNTER) are
//   accepted but dropped. Nothing is issued for them, and drop_count is
//   incremented.

module cms_ctrl_sequencer #(
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] req0_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] req0_wdata,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [CTRL_ADDR_WIDTH-1:0] req1_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] req1_wdata,
  output logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic                       busy,
`ifdef CMS_CTRL_SEQ_ADDR_CHECK_EN
  output logic [15:0]                drop_count,
`endif
  output logic [31:0]                issued_count
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Counters are loaded with N-1 so that a phase lasts exactly N cycles.
  localparam logic [3:0] PulseInit = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GapInit   = 4'(GAP_CYCLES - 1);

  state_t                     state_q, state_d;
  logic                       lastGrant_q, lastGrant_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CTRL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]                issuedCount_q, issuedCount_d;

  logic                       grant0, grant1, isIdle, handshake, addrOk;
  logic [CTRL_ADDR_WIDTH-1:0] selAddr;
  logic [CTRL_DATA_WIDTH-1:0] selData;

  // Round-robin arbitration. Requester 1 wins only when it is the sole
  // requester, or when requester 0 was granted last.
  assign grant1    = req1_valid & (~req0_valid | ~lastGrant_q);
  assign grant0    = req0_valid & ~grant1;
  assign isIdle    = (state_q == IDLE);
  assign req0_ready = grant0 & isIdle;
  assign req1_ready = grant1 & isIdle;
  assign handshake = req0_ready | req1_ready;
  assign selAddr   = grant1 ? req1_addr  : req0_addr;
  assign selData   = grant1 ? req1_wdata : req0_wdata;

`ifdef CMS_CTRL_SEQ_ADDR_CHECK_EN
  localparam logic [CTRL_ADDR_WIDTH-1:0] MaxAddr = CTRL_ADDR_WIDTH'(9);
  logic [15:0] dropCount_q, dropCount_d;

  assign addrOk = (selAddr <= MaxAddr);

  always_comb begin
    dropCount_d = dropCount_q;
    if (handshake && !addrOk && dropCount_q != 16'hFFFF) begin
      dropCount_d = dropCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCount_q <= '0;
    end else begin
      dropCount_q <= dropCount_d;
    end
  end

  assign drop_count = dropCount_q;
`else
  assign addrOk = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    lastGrant_d   = lastGrant_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    issuedCount_d = issuedCount_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          lastGrant_d = grant1;
          // A dropped write remains in IDLE. The sequencer is therefore
          // idle again on the cycle after the handshake.
          if (addrOk) begin
            addr_d  = selAddr;
            wdata_d = selData;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d       = STROBE;
        cnt_d         = PulseInit;
        issuedCount_d = issuedCount_q + 32'd1;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = GapInit;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lastGrant resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lastGrant_q   <= 1'b1;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      issuedCount_q <= '0;
    end else begin
      state_q       <= state_d;
      lastGrant_q   <= lastGrant_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      issuedCount_q <= issuedCount_d;
    end
  end

  // The strobe is decoded directly from the state register. An asynchronous
  // reset therefore drops it immediately.
  assign ctrl_write_enable = (state_q == STROBE);
  assign busy              = ~isIdle;
  assign ctrl_addr         = addr_q;
  assign ctrl_wdata        = wdata_q;
  assign issued_count      = issuedCount_q;

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// tb_cms_ctrl_sequencer
//
// Directed testbench for cms_ctrl_sequencer.
// Instance A uses the default timing (PULSE=1, GAP=2).
// Instance B uses PULSE=3, GAP=4.
// A small model of a posedge-mode monitor register file latches
// instance A's writes.

module tb_cms_ctrl_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req0ValidA, req1ValidA, req0ReadyA, req1ReadyA, weA, busyA;
  logic [7:0]  req0AddrA, req1AddrA, ctrlAddrA;
  logic [63:0] req0DataA, req1DataA, ctrlDataA;
  logic [31:0] issuedA;

  logic        req0ValidB, req1ValidB, req0ReadyB, req1ReadyB, weB, busyB;
  logic [7:0]  req0AddrB, req1AddrB, ctrlAddrB;
  logic [63:0] req0DataB, req1DataB, ctrlDataB;
  logic [31:0] issuedB;

`ifdef CMS_CTRL_SEQ_ADDR_CHECK_EN
  logic [15:0] dropA, dropB;
`endif

  int vecCount  = 0;
  int missCount = 0;

  cms_ctrl_sequencer uA (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0ValidA), .req0_ready(req0ReadyA),
    .req0_addr(req0AddrA), .req0_wdata(req0DataA),
    .req1_valid(req1ValidA), .req1_ready(req1ReadyA),
    .req1_addr(req1AddrA), .req1_wdata(req1DataA),
    .ctrl_addr(ctrlAddrA), .ctrl_wdata(ctrlDataA),
    .ctrl_write_enable(weA), .busy(busyA),
`ifdef CMS_CTRL_SEQ_ADDR_CHECK_EN
    .drop_count(dropA),
`endif
    .issued_count(issuedA)
  );

  cms_ctrl_sequencer #(.PULSE_CYCLES(3), .GAP_CYCLES(4)) uB (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0ValidB), .req0_ready(req0ReadyB),
    .req0_addr(req0AddrB), .req0_wdata(req0DataB),
    .req1_valid(req1ValidB), .req1_ready(req1ReadyB),
    .req1_addr(req1AddrB), .req1_wdata(req1DataB),
    .ctrl_addr(ctrlAddrB), .ctrl_wdata(ctrlDataB),
    .ctrl_write_enable(weB), .busy(busyB),
`ifdef CMS_CTRL_SEQ_ADDR_CHECK_EN
    .drop_count(dropB),
`endif
    .issued_count(issuedB)
  );

  // Posedge-mode monitor model: it latches a register on each rising edge of
  // the write enable.
  logic        monPrevWe, monLbEn;
  logic [63:0] monLb;
  int          latchCount = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      monPrevWe <= 1'b0;
      monLbEn   <= 1'b0;
      monLb     <= '0;
    end else begin
      monPrevWe <= weA;
      if (weA && !monPrevWe) begin
        latchCount <= latchCount + 1;
        if (ctrlAddrA == 8'd4) monLbEn <= ctrlDataA[0];
        if (ctrlAddrA == 8'd6) monLb   <= ctrlDataA;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drives one request on instance A and waits (bounded) for the handshake.
  // It returns one step after the handshake cycle.
  task automatic applyStimulus(input bit reqSel, input logic [7:0] addr,
                               input logic [63:0] data, output bit seen);
    seen = 1'b0;
    if (reqSel) begin
      req1ValidA = 1'b1; req1AddrA = addr; req1DataA = data;
    end else begin
      req0ValidA = 1'b1; req0AddrA = addr; req0DataA = data;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = reqSel ? req1ReadyA : req0ReadyA;
      stepCycle();
    end
    req0ValidA = 1'b0;
    req1ValidA = 1'b0;
  endtask

  bit seen;
  int grants, strobes, lc0;
  bit grantWho[8];
  int grantAt[8];

  initial begin
    rst_n = 1'b0;
    req0ValidA = 0; req1ValidA = 0; req0AddrA = 0; req1AddrA = 0; req0DataA = 0; req1DataA = 0;
    req0ValidB = 0; req1ValidB = 0; req0AddrB = 0; req1AddrB = 0; req0DataB = 0; req1DataB = 0;
    applyReset();

    // Reset state
    @(negedge clk);
    checkOutput("rst_we",      64'(weA), 64'd0);
    checkOutput("rst_busy",    64'(busyA), 64'd0);
    checkOutput("rst_ready0",  64'(req0ReadyA), 64'd0);
    checkOutput("rst_addr",    64'(ctrlAddrA), 64'd0);
    checkOutput("rst_data",    ctrlDataA, 64'd0);
    checkOutput("rst_issued",  64'(issuedA), 64'd0);
    stepCycle();

    // Single write: strobe at N+2 only, data held, idle at N+5
    applyStimulus(1'b0, 8'd2, 64'h8000_0100, seen);
    checkOutput("sw_handshake", 64'(seen), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("sw_we",   64'(weA),   64'(k == 2));
      checkOutput("sw_busy", 64'(busyA), 64'(k < 5));
      checkOutput("sw_ready0", 64'(req0ReadyA), 64'd0);
      checkOutput("sw_addr", 64'(ctrlAddrA), 64'd2);
      checkOutput("sw_data", ctrlDataA, 64'h8000_0100);
      stepCycle();
    end
    checkOutput("sw_issued", 64'(issuedA), 64'd1);

    // Monitor integration: addr 4 <= 1, addr 6 <= 0x1000
    lc0 = latchCount;
    applyStimulus(1'b0, 8'd4, 64'd1, seen);
    checkOutput("mon_hs4", 64'(seen), 64'd1);
    repeat (4) stepCycle();
    applyStimulus(1'b1, 8'd6, 64'h1000, seen);
    checkOutput("mon_hs6", 64'(seen), 64'd1);
    repeat (4) stepCycle();
    checkOutput("mon_lb_en",   64'(monLbEn), 64'd1);
    checkOutput("mon_lb",      monLb, 64'h1000);
    checkOutput("mon_latches", 64'(latchCount - lc0), 64'd2);
    checkOutput("mon_issued",  64'(issuedA), 64'd3);

`ifdef CMS_CTRL_SEQ_ADDR_CHECK_EN
    // Out-of-range address is accepted and dropped
    applyStimulus(1'b1, 8'h20, 64'hdead, seen);
    checkOutput("drop_hs", 64'(seen), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("drop_we",   64'(weA), 64'd0);
      checkOutput("drop_busy", 64'(busyA), 64'd0);
      stepCycle();
    end
    checkOutput("drop_count",  64'(dropA), 64'd1);
    checkOutput("drop_addr",   64'(ctrlAddrA), 64'd6);
    checkOutput("drop_issued", 64'(issuedA), 64'd3);
`endif

    // Parameter sweep on B: 3-cycle strobe, then 4 low; next handshake 9 later
    req0ValidB = 1'b1; req0AddrB = 8'd5; req0DataB = 64'h55;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      checkOutput("sweep_ready", 64'(req0ReadyB), 64'(k == 0 || k == 9));
      checkOutput("sweep_we",    64'(weB), 64'(k >= 2 && k <= 4));
      checkOutput("sweep_busy",  64'(busyB), 64'(k >= 1 && k <= 8));
      stepCycle();
    end
    req0ValidB = 1'b0;
    checkOutput("sweep_issued", 64'(issuedB), 64'd1);

    // Contention from reset: req0, req1, req0, req1 at 5-cycle spacing
    req0ValidA = 1'b1; req0AddrA = 8'd1; req0DataA = 64'h11;
    req1ValidA = 1'b1; req1AddrA = 8'd3; req1DataA = 64'h33;
    applyReset();
    grants = 0;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req0ReadyA && req1ReadyA) checkOutput("ct_both_ready", 64'd1, 64'd0);
      if (req0ReadyA || req1ReadyA) begin
        if (grants < 8) begin
          grantWho[grants] = req1ReadyA;
          grantAt[grants]  = c;
        end
        grants++;
      end
      if (weA) strobes++;
      stepCycle();
    end
    req0ValidA = 1'b0;
    req1ValidA = 1'b0;
    checkOutput("ct_grants",  64'(grants), 64'd4);
    checkOutput("ct_strobes", 64'(strobes), 64'd4);
    for (int i = 0; i < 4 && i < grants; i++)
      checkOutput("ct_order", 64'(grantWho[i]), 64'(i % 2));
    for (int i = 1; i < 4 && i < grants; i++)
      checkOutput("ct_spacing", 64'(grantAt[i] - grantAt[i-1]), 64'd5);
    checkOutput("ct_last_addr", 64'(ctrlAddrA), 64'd3);
    repeat (2) stepCycle();

    // Reset asserted mid-strobe
    applyStimulus(1'b0, 8'd7, 64'h77, seen);
    checkOutput("rs_hs", 64'(seen), 64'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("rs_we_before", 64'(weA), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rs_we_async", 64'(weA), 64'd0);
    checkOutput("rs_busy",     64'(busyA), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rs_post_we",     64'(weA), 64'd0);
    checkOutput("rs_post_busy",   64'(busyA), 64'd0);
    checkOutput("rs_post_addr",   64'(ctrlAddrA), 64'd0);
    checkOutput("rs_post_data",   ctrlDataA, 64'd0);
    checkOutput("rs_post_issued", 64'(issuedA), 64'd0);
    checkOutput("rs_post_ready",  64'({req0ReadyA, req1ReadyA}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
